// File: rtl/fetcher_sa_icache_pkg.sv
// Shared constants for the set-associative fetcher: widths, literals, FSM encodings
// and the helpers that derive PC field boundaries from the cache geometry.
package fetcher_sa_icache_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] NULL  = '0;
    localparam logic              TRUE  = 1'b1;
    localparam logic              FALSE = 1'b0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // PC layout: [tag | index | offset | 2'b00]
    function automatic int idx_lo(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int tag_lo(input int sets, input int line_words);
        return idx_lo(line_words) + $clog2(sets);
    endfunction

endpackage

// File: rtl/fetcher_sa_icache_if.sv
// Refill bus between the fetcher (master) and the memory controller (slave).
interface fetcher_sa_icache_if #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4
);
    logic                    mem_en;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_abort;
    logic                    mem_done;
    logic [32*LINE_WORDS-1:0] mem_line;

    modport master (output mem_en, mem_addr, mem_abort, input mem_done, mem_line);
    modport slave  (input mem_en, mem_addr, mem_abort, output mem_done, mem_line);
endinterface

// File: rtl/fetcher_sa_icache_way_array.sv
// One way of the icache: tag/valid/data per set, combinational reads,
// synchronous line write and whole-way invalidate.
module icache_way_array #(
    parameter int TAG_W  = 24,
    parameter int SETS   = 16,
    parameter int IDX_W  = 4,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_line,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic [IDX_W-1:0]  vic_idx,
    output logic              vic_valid
);
    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tags [SETS];
    logic [LINE_W-1:0] data [SETS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid <= '0;
        else if (clear)
            valid <= '0;
        else if (wr_en)
            valid[wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_line;
        end
    end

    assign rd_valid  = valid[rd_idx];
    assign rd_tag    = tags[rd_idx];
    assign rd_line   = data[rd_idx];
    assign vic_valid = valid[vic_idx];

endmodule

// File: rtl/fetcher_sa_icache.sv
// Fetch unit: PC, refill FSM, victim selection and issue register in front of
// an N-way set-associative instruction cache.
module fetcher_sa_icache
    import fetcher_sa_icache_pkg::*;
#(
    parameter int ADDR_W     = fetcher_sa_icache_pkg::ADDR_W,
    parameter int WAYS       = 2,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              full,
    input  logic              rollback,
    input  logic [ADDR_W-1:0] rollback_pc,
    input  logic              flush,
    output logic [ADDR_W-1:0] pdt_pc,
    output logic [INST_W-1:0] pdt_inst,
    input  logic              pdt_taken,
    input  logic [ADDR_W-1:0] pdt_target,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              out_taken,
    output logic [ADDR_W-1:0] out_fall_pc,
    fetcher_sa_icache_if.master mem
);
    localparam int IDX_LO = idx_lo(LINE_WORDS);
    localparam int TAG_LO = tag_lo(SETS, LINE_WORDS);
    localparam int IDX_W  = TAG_LO - IDX_LO;
    localparam int OFF_W  = IDX_LO - 2;
    localparam int TAG_W  = ADDR_W - TAG_LO;
    localparam int LINE_W = INST_W * LINE_WORDS;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [ADDR_W-1:0] pc;
    logic [0:0]        state;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;

    logic [OFF_W-1:0] pc_off;
    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    assign pc_off = pc[IDX_LO-1:2];
    assign pc_idx = pc[TAG_LO-1:IDX_LO];
    assign pc_tag = pc[ADDR_W-1:TAG_LO];

    logic [WAYS-1:0]   way_valid;
    logic [WAYS-1:0]   way_vic_valid;
    logic [TAG_W-1:0]  way_tag  [WAYS];
    logic [LINE_W-1:0] way_line [WAYS];

    logic             fill_now;
    logic             clear_all;
    logic [WAY_W-1:0] victim;
    logic [WAY_W-1:0] rr_cur;
    logic             found_invalid;

    // A fill is dropped when it collides with a flush; rollback does not stop it.
    assign fill_now  = rdy && !flush && (state == ST_WAIT) && mem.mem_done;
    assign clear_all = rdy && flush;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way_array #(
            .TAG_W (TAG_W),
            .SETS  (SETS),
            .IDX_W (IDX_W),
            .LINE_W(LINE_W)
        ) u_way (
            .clk      (clk),
            .rst      (rst),
            .clear    (clear_all),
            .wr_en    (fill_now && (victim == WAY_W'(w))),
            .wr_idx   (fill_idx),
            .wr_tag   (fill_tag),
            .wr_line  (mem.mem_line),
            .rd_idx   (pc_idx),
            .rd_valid (way_valid[w]),
            .rd_tag   (way_tag[w]),
            .rd_line  (way_line[w]),
            .vic_idx  (fill_idx),
            .vic_valid(way_vic_valid[w])
        );
    end

    logic              hit;
    logic [LINE_W-1:0] hit_line;
    logic [INST_W-1:0] hit_word;

    always_comb begin
        hit      = FALSE;
        hit_line = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (way_valid[w] && (way_tag[w] == pc_tag)) begin
                hit      = TRUE;
                hit_line = hit_line | way_line[w];
            end
        end
        hit_word = hit_line[INST_W*int'(pc_off) +: INST_W];
    end

    assign pdt_pc   = pc;
    assign pdt_inst = hit ? hit_word : NULL;

    always_comb begin
        victim        = rr_cur;
        found_invalid = FALSE;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!found_invalid && !way_vic_valid[w]) begin
                victim        = WAY_W'(w);
                found_invalid = TRUE;
            end
        end
    end

    if (WAYS > 1) begin : g_rr
        logic [WAY_W-1:0] rr [SETS];

        // Pointer advances only when the fill had to evict a valid line.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int unsigned s = 0; s < SETS; s++) rr[s] <= '0;
            end else if (rdy) begin
                if (flush) begin
                    for (int unsigned s = 0; s < SETS; s++) rr[s] <= '0;
                end else if (fill_now && !found_invalid) begin
                    rr[fill_idx] <= rr[fill_idx] + WAY_W'(1);
                end
            end
        end
        assign rr_cur = rr[fill_idx];
    end else begin : g_no_rr
        assign rr_cur = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= '0;
            state         <= ST_IDLE;
            fill_idx      <= '0;
            fill_tag      <= '0;
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_inst      <= '0;
            out_taken     <= 1'b0;
            out_fall_pc   <= '0;
            mem.mem_en    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_abort <= 1'b0;
        end else if (rdy) begin
            mem.mem_en    <= 1'b0;
            mem.mem_abort <= 1'b0;
            out_valid     <= 1'b0;
            if (flush) begin
                if (state == ST_WAIT) mem.mem_abort <= 1'b1;
                state <= ST_IDLE;
                if (rollback) pc <= rollback_pc;
            end else if (rollback) begin
                pc    <= rollback_pc;
                state <= ST_IDLE;
                if ((state == ST_WAIT) && !mem.mem_done) mem.mem_abort <= 1'b1;
            end else begin
                if (hit && !full) begin
                    out_valid   <= 1'b1;
                    out_pc      <= pc;
                    out_inst    <= hit_word;
                    out_taken   <= pdt_taken;
                    out_fall_pc <= pc + ADDR_W'(4);
                    pc          <= pdt_taken ? pdt_target : pc + ADDR_W'(4);
                end
                case (state)
                    ST_IDLE: begin
                        if (!hit) begin
                            mem.mem_en   <= 1'b1;
                            mem.mem_addr <= {pc[ADDR_W-1:IDX_LO], {IDX_LO{1'b0}}};
                            fill_idx     <= pc_idx;
                            fill_tag     <= pc_tag;
                            state        <= ST_WAIT;
                        end
                    end
                    default: begin
                        if (mem.mem_done) state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
